// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared width, step-counter width and FSM encoding for the serial multiplier scheduler
package mult_sched_pkg;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mult_serial_dp.sv
// mult_serial_dp: bit-serial shift-add datapath (acc, mcand, mplier, step counter), one multiplier bit per step
module mult_serial_dp
    import mult_sched_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int CW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] acc_next_o,
    output logic           mplier_zero_o,
    output logic           last_step_o
);
    logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // one shift-add step; status looks at the state after the step in progress
    always_comb begin
        acc_next_o    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mplier_zero_o = mplier_q[W-1:1] == '0;
        last_step_o   = cnt_q == CW'(W - 1);
        acc_d         = load_i ? '0 : step_i ? acc_next_o : acc_q;
        mcand_d       = load_i ? {{W{1'b0}}, a_i} : step_i ? mcand_q << 1 : mcand_q;
        mplier_d      = load_i ? b_i : step_i ? mplier_q >> 1 : mplier_q;
        cnt_d         = load_i ? '0 : step_i ? cnt_q + CW'(1) : cnt_q;
    end

    // datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/mult_sched.sv
// mult_sched: round-robin two-client scheduler/sequencer for the serial multiplier; MULT_SCHED_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int WIDTH = mult_sched_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [2*WIDTH-1:0] product
);
`ifdef MULT_SCHED_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t             state_q, state_d;
    logic               last_id_q, last_id_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic               done_id_q, done_id_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               win, load, step, term, finish;
    logic               mplier_zero, last_step;
    logic [2*WIDTH-1:0] acc_next;

    mult_serial_dp #(.W(WIDTH)) u_dp (
        .clk           (clk),
        .reset         (reset),
        .load_i        (load),
        .step_i        (step),
        .a_i           (win ? a1 : a0),
        .b_i           (win ? b1 : b0),
        .acc_next_o    (acc_next),
        .mplier_zero_o (mplier_zero),
        .last_step_o   (last_step)
    );

    // arbitration (ties go to the client not served last) and datapath control
    always_comb begin
        win       = (req0 & req1) ? ~last_id_q : req1;
        load      = state_q == IDLE && (req0 | req1);
        step      = state_q == RUN;
        term      = last_step | (EARLY_EXIT & mplier_zero);
        finish    = step & term;
        gnt0_d    = load & ~win;
        gnt1_d    = load & win;
        last_id_d = load ? win : last_id_q;
        product_d = finish ? acc_next : product_q;
        done_id_d = finish ? last_id_q : done_id_q;
    end

    // next-state logic
    always_comb begin
        state_d = state_q == IDLE ? ((req0 | req1) ? RUN : IDLE) :
                  state_q == RUN  ? (term ? DONE : RUN) : IDLE;
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_id_q <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_id_q <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_id_q <= done_id_d;
            product_q <= product_d;
        end
    end

    // outputs: registered values plus state decode
    always_comb begin
        gnt0    = gnt0_q;
        gnt1    = gnt1_q;
        busy    = state_q != IDLE;
        done    = state_q == DONE;
        done_id = done_id_q;
        product = product_q;
    end
endmodule
